reg_share_arb: RTL and testbench

Round-robin arbiter that shares one synchronous-reset DWIDTH holding register among NREQ requesters. Each cycle it picks at most one requesting source, exposes a combinational one-hot grant, and captures the winner's data into the shared register at the next rising edge. The block sits in front of shared state (CSR shadow, debug/result latch) that several pipeline agents write.

---
 rtl/reg_share_arb.sv | 102 ++++++++++
 tb/tb_reg_share_arb.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/reg_share_arb.sv
// reg_share_arb: round-robin arbiter in front of one shared DWIDTH holding
// register. Each cycle at most one requester wins a combinational one-hot
// grant, and its data is captured into the shared register at the next edge.
// Optional owner lock/burst support is enabled by defining the macro
// REG_SHARE_ARB_LOCK_EN. When it is undefined, lock_i is ignored.
module reg_share_arb #(
  parameter  int NREQ   = 4,
  parameter  int DWIDTH = 32,
  localparam int IDW    = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_i,
  input  logic [NREQ*DWIDTH-1:0] data_i,
  input  logic [NREQ-1:0]        lock_i,
  output logic [NREQ-1:0]        gnt_o,
  output logic [DWIDTH-1:0]      out_o,
  output logic                   out_valid_o,
  output logic [IDW-1:0]         owner_o
);

  logic [IDW-1:0]    ptr_q, ptr_d;
  logic [IDW-1:0]    owner_q, owner_d;
  logic [DWIDTH-1:0] out_q, out_d;
  logic              valid_q, valid_d;

  logic              rr_valid;
  logic [IDW-1:0]    rr_idx;
  logic              lock_hit;
  logic              win_valid;
  logic [IDW-1:0]    win_idx;
  logic [IDW:0]      idx_wide;

`ifdef REG_SHARE_ARB_LOCK_EN
  // The current owner keeps the register while it holds both request and lock.
  assign lock_hit = req_i[owner_q] & lock_i[owner_q];
`else
  logic unused_lock;
  assign unused_lock = ^lock_i;
  assign lock_hit    = 1'b0;
`endif

  // Round-robin search: first requester at or after ptr, wrapping modulo NREQ.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    rr_valid = 1'b0;
    rr_idx   = '0;
    idx_wide = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx_wide = {1'b0, ptr_q} + (IDW+1)'(i);
      if (idx_wide >= (IDW+1)'(NREQ)) idx_wide = idx_wide - (IDW+1)'(NREQ);
      if (!rr_valid && req_i[idx_wide[IDW-1:0]]) begin
        rr_valid = 1'b1;
        rr_idx   = idx_wide[IDW-1:0];
      end
    end
  end

  // Final winner selection. A lock overrides the pointer, and the grant is one-hot.
  always_comb begin
    win_valid = rr_valid | lock_hit;
    win_idx   = lock_hit ? owner_q : rr_idx;
    gnt_o     = win_valid ? (NREQ'(1) << win_idx) : '0;
  end

  // Next-state logic for the shared register, its owner and the priority pointer.
  always_comb begin
    out_d   = out_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    valid_d = win_valid;
    if (win_valid) begin
      out_d   = data_i[win_idx*DWIDTH +: DWIDTH];
      owner_d = win_idx;
      if (!lock_hit) begin
        // Explicit wrap, so non-power-of-two NREQ works.
        ptr_d = (win_idx == IDW'(NREQ-1)) ? '0 : win_idx + 1'b1;
      end
    end
  end

  // State registers. A synchronous reset overrides any capture.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
    if (rst) begin
      out_q   <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
    end
  end

  assign out_o       = out_q;
  assign out_valid_o = valid_q;
  assign owner_o     = owner_q;

endmodule

// File: tb/tb_reg_share_arb.sv
// Self-checking bench for reg_share_arb (NREQ=4, DWIDTH=32).
// A behavioural model predicts the grant and the register contents every cycle.
// Directed literal checks pin the model to hand-computed values.
module tb_reg_share_arb;
  localparam int NREQ   = 4;
  localparam int DWIDTH = 32;
  localparam int IDW    = 2;

  logic                   clk;
  logic                   rst;
  logic [NREQ-1:0]        req_i;
  logic [NREQ*DWIDTH-1:0] data_i;
  logic [NREQ-1:0]        lock_i;
  logic [NREQ-1:0]        gnt_o;
  logic [DWIDTH-1:0]      out_o;
  logic                   out_valid_o;
  logic [IDW-1:0]         owner_o;

  int n_checks = 0;
  int n_errors = 0;

  reg_share_arb #(.NREQ(NREQ), .DWIDTH(DWIDTH)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .data_i(data_i), .lock_i(lock_i),
    .gnt_o(gnt_o), .out_o(out_o), .out_valid_o(out_valid_o), .owner_o(owner_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_ptr, m_owner, m_valid;
  logic [31:0] m_out;
  bit          m_live = 0;

  function automatic bit m_locked();
`ifdef REG_SHARE_ARB_LOCK_EN
    return req_i[m_owner] && lock_i[m_owner];
`else
    return 0;
`endif
  endfunction

  // Returns the winning index, or -1 when nobody requests.
  function automatic int m_pick();
    if (m_locked()) return m_owner;
    for (int i = 0; i < NREQ; i++)
      if (req_i[(m_ptr + i) % NREQ]) return (m_ptr + i) % NREQ;
    return -1;
  endfunction

  always @(posedge clk) begin
    int w;
    w = m_pick();
    if (rst) begin
      m_ptr = 0; m_owner = 0; m_out = 0; m_valid = 0;
    end else if (w < 0) begin
      m_valid = 0;
    end else begin
      if (!m_locked()) m_ptr = (w + 1) % NREQ;
      m_owner = w;
      m_out   = data_i[w*DWIDTH +: DWIDTH];
      m_valid = 1;
    end
    m_live = 1;
  end

  // Compare process: mid-cycle, inputs and outputs are stable.
  always @(negedge clk) begin
    if (m_live) begin
      int w;
      w = m_pick();
      check("model_gnt", 64'(gnt_o), (w < 0) ? 64'd0 : 64'(1) << w);
      check("model_out", 64'(out_o), 64'(m_out));
      check("model_valid", 64'(out_valid_o), 64'(m_valid));
      check("model_owner", 64'(owner_o), 64'(m_owner));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic drive(input logic r, input logic [3:0] rq, input logic [3:0] lk);
    @(posedge clk);
    #1;
    rst = r; req_i = rq; lock_i = lk;
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [31:0] o, input logic v,
                            input logic [1:0] own, input logic [3:0] g);
    check({tag, "_out"},   64'(out_o),       64'(o));
    check({tag, "_valid"}, 64'(out_valid_o), 64'(v));
    check({tag, "_owner"}, 64'(owner_o),     64'(own));
    check({tag, "_gnt"},   64'(gnt_o),       64'(g));
  endtask

  initial begin
    logic [3:0] g;
    rst = 1'b1; req_i = 4'b1111; lock_i = 4'b0000;
    for (int k = 0; k < NREQ; k++) data_i[k*DWIDTH +: DWIDTH] = 32'h10 + k;

    // Reset for two edges with all requests asserted. The grant is still computed from ptr=0.
    drive(1'b1, 4'b1111, 4'b0000);
    expect_out("rst1", 32'h0, 1'b0, 2'd0, 4'b0001);
    drive(1'b0, 4'b1111, 4'b0000);
    expect_out("rst2", 32'h0, 1'b0, 2'd0, 4'b0001);

    // Rotation: owners 0,1,2,3,0.
    for (int j = 0; j < 5; j++) begin
      drive(1'b0, 4'b1111, 4'b0000);
      g = 4'b0001 << ((j + 1) % 4);
      expect_out($sformatf("rot%0d", j), 32'h10 + (j % 4), 1'b1, 2'(j % 4), g);
    end
    // ptr=1 here. Grant 2 so that ptr becomes 3.
    drive(1'b0, 4'b0100, 4'b0000);  // gnt 0100 this cycle
    drive(1'b0, 4'b0011, 4'b0000);
    expect_out("wrap_a", 32'h12, 1'b1, 2'd2, 4'b0001);
    drive(1'b0, 4'b0011, 4'b0000);
    expect_out("wrap_b", 32'h10, 1'b1, 2'd0, 4'b0010);
    // ptr=2. Requester 2 writes 0xABCD, then one idle cycle follows.
    data_i[2*DWIDTH +: DWIDTH] = 32'hABCD;
    drive(1'b0, 4'b0100, 4'b0000);
    drive(1'b0, 4'b0000, 4'b0000);
    expect_out("idle_a", 32'hABCD, 1'b1, 2'd2, 4'b0000);
    drive(1'b0, 4'b1111, 4'b0000);
    expect_out("idle_b", 32'hABCD, 1'b0, 2'd2, 4'b1000);
    // Mid-stream reset while requester 2 asks (ptr=0 so 2 is granted).
    drive(1'b1, 4'b0100, 4'b0000);
    expect_out("mrst_a", 32'h13, 1'b1, 2'd3, 4'b0100);
    drive(1'b0, 4'b0110, 4'b0000);
    expect_out("mrst_b", 32'h0, 1'b0, 2'd0, 4'b0010);
    // ptr=2. Requester 2 wins, then the lock stimulus is applied.
    data_i[2*DWIDTH +: DWIDTH] = 32'h12;
    drive(1'b0, 4'b0100, 4'b0000);
    expect_out("lk_pre", 32'h11, 1'b1, 2'd1, 4'b0100);
    for (int j = 0; j < 3; j++) begin
      drive(1'b0, 4'b0111, 4'b0100);
`ifdef REG_SHARE_ARB_LOCK_EN
      check($sformatf("lock_gnt%0d", j), 64'(gnt_o), 64'b0100);
`else
      check($sformatf("lock_gnt%0d", j), 64'(gnt_o), 64'(4'b0001 << j));
`endif
    end
    drive(1'b0, 4'b0111, 4'b0000);
`ifdef REG_SHARE_ARB_LOCK_EN
    check("lock_release", 64'(gnt_o), 64'b0001);
`else
    check("lock_release", 64'(gnt_o), 64'b0001);
    check("lock_release_owner", 64'(owner_o), 64'd2);
`endif

    // Mixed vectors, checked by the model only.
    for (int j = 0; j < 40; j++) begin
      for (int k = 0; k < NREQ; k++) data_i[k*DWIDTH +: DWIDTH] = $urandom;
      drive((j % 17) == 16, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end
    drive(1'b0, 4'b0000, 4'b0000);
    @(posedge clk);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
